// File: rtl/dm_resp_if.sv
// dm_resp_if -- M-stage request / W-stage response bundle for the data-memory
// responder.
//   master : M-stage controller (drives M_*, observes W_*)
//   slave  : dm_resp            (observes M_*, drives W_*)
//   M_valid    real instruction in M (0 = bubble)
//   M_DM_WE    store;  M_DM_re  load  (never both)
//   M_DM_op    access code: word / half(u,s) / byte(u,s); 101-111 reserved
//   M_addr     byte address;  M_wdata  store data
//   W_valid    registered M_valid
//   W_DM_rdata registered, extended load data (0 unless a clean load)
//   W_DM_exc   registered alignment/range/op fault
interface dm_resp_if;
  logic        M_valid;
  logic        M_DM_WE;
  logic        M_DM_re;
  logic [2:0]  M_DM_op;
  logic [31:0] M_addr;
  logic [31:0] M_wdata;
  logic        W_valid;
  logic [31:0] W_DM_rdata;
  logic        W_DM_exc;

  modport master (
    output M_valid, M_DM_WE, M_DM_re, M_DM_op, M_addr, M_wdata,
    input  W_valid, W_DM_rdata, W_DM_exc
  );

  modport slave (
    input  M_valid, M_DM_WE, M_DM_re, M_DM_op, M_addr, M_wdata,
    output W_valid, W_DM_rdata, W_DM_exc
  );
endinterface

// File: rtl/dm_resp.sv
// dm_resp -- memory-stage data-memory responder.
// Holds a WORDS x 32-bit array split into four byte-lane banks, performs
// byte/half/word stores with lane enables, extracts and extends loads, and
// registers load data plus a fault flag into the M/W boundary.
//   clk   : pipeline clock, rising edge
//   reset : asynchronous, active-low; clears array and W outputs
//   bus   : dm_resp_if.slave (M-stage request in, W-stage response out)

// One byte lane of the array: WORDS x 8 bits, async-clear, comb read.
module dm_lane #(
  parameter int WORDS = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] idx_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);
  logic [7:0] mem_q [WORDS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WORDS; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[idx_i];
endmodule

module dm_resp #(
  parameter int WORDS = 1024
) (
  input  logic     clk,
  input  logic     reset,
  dm_resp_if.slave bus
);
  localparam int NUM_LANES = 4;
  localparam int AW        = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [2:0] OP_W  = 3'b000;
  localparam logic [2:0] OP_HU = 3'b001;
  localparam logic [2:0] OP_H  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b011;
  localparam logic [2:0] OP_B  = 3'b100;

  typedef struct packed {
    logic        exc;
    logic [31:0] rdata;
  } resp_t;

  resp_t resp_d, resp_q;
  logic  vld_q;

  logic        is_word, is_half, is_byte, rsvd;
  logic        oor, misal, access, fault;
  logic [NUM_LANES-1:0] be, lane_we;
  logic [31:0] wdata_rep;
  logic [AW-1:0] idx;
  logic [NUM_LANES-1:0][7:0] rd_lane;
  logic [31:0] rd_word;
  logic [15:0] rd_half;
  logic [7:0]  rd_byte;
  logic [31:0] ld_ext;

  // ---------------- decode / fault ----------------
  assign is_word = (bus.M_DM_op == OP_W);
  assign is_half = (bus.M_DM_op == OP_HU) | (bus.M_DM_op == OP_H);
  assign is_byte = (bus.M_DM_op == OP_BU) | (bus.M_DM_op == OP_B);
  assign rsvd    = ~(is_word | is_half | is_byte);

  // Compare the full word index so high addresses fault instead of aliasing.
  assign oor    = (bus.M_addr[31:2] >= 30'(WORDS));
  assign misal  = (is_word & (|bus.M_addr[1:0])) | (is_half & bus.M_addr[0]);
  assign access = bus.M_valid & (bus.M_DM_WE | bus.M_DM_re);
  assign fault  = access & (oor | rsvd | misal);

  // ---------------- store lanes ----------------
  always_comb begin
    be = '0;
    if (is_word)      be = 4'hF;
    else if (is_half) be = bus.M_addr[1] ? 4'hC : 4'h3;
    else if (is_byte) be = 4'b0001 << bus.M_addr[1:0];
  end

  assign lane_we = {NUM_LANES{bus.M_valid & bus.M_DM_WE & ~fault}} & be;

  // Replicating the narrow data lets every lane take its slice unconditionally.
  assign wdata_rep = is_word ? bus.M_wdata :
                     is_half ? {2{bus.M_wdata[15:0]}} :
                               {4{bus.M_wdata[7:0]}};

  assign idx = bus.M_addr[AW+1:2];

  for (genvar gl = 0; gl < NUM_LANES; gl++) begin : g_lane
    dm_lane #(.WORDS(WORDS), .AW(AW)) u_lane (
      .clk     (clk),
      .rst_n   (reset),
      .we_i    (lane_we[gl]),
      .idx_i   (idx),
      .wdata_i (wdata_rep[8*gl +: 8]),
      .rdata_o (rd_lane[gl])
    );
  end

  // ---------------- load extract / extend ----------------
  assign rd_word = rd_lane;
  assign rd_half = bus.M_addr[1] ? rd_word[31:16] : rd_word[15:0];
  assign rd_byte = rd_lane[bus.M_addr[1:0]];

  always_comb begin
    ld_ext = '0;
    case (bus.M_DM_op)
      OP_W:    ld_ext = rd_word;
      OP_HU:   ld_ext = {16'h0, rd_half};
      OP_H:    ld_ext = {{16{rd_half[15]}}, rd_half};
      OP_BU:   ld_ext = {24'h0, rd_byte};
      OP_B:    ld_ext = {{24{rd_byte[7]}}, rd_byte};
      default: ld_ext = '0;
    endcase
  end

  always_comb begin
    resp_d       = '0;
    resp_d.exc   = fault;
    resp_d.rdata = (bus.M_valid & bus.M_DM_re & ~fault) ? ld_ext : 32'h0;
  end

  // ---------------- M/W register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q  <= 1'b0;
      resp_q <= '0;
    end else begin
      vld_q  <= bus.M_valid;
      resp_q <= resp_d;
    end
  end

  assign bus.W_valid    = vld_q;
  assign bus.W_DM_rdata = resp_q.rdata;
  assign bus.W_DM_exc   = resp_q.exc;
endmodule

// File: tb/tb_dm_resp.sv
// tb_dm_resp -- directed bench for dm_resp (WORDS=1024).
module tb_dm_resp;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  dm_resp_if bus ();

  dm_resp #(.WORDS(1024)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] W = 3'b000, HU = 3'b001, H = 3'b010,
                         BU = 3'b011, B = 3'b100;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expw(input string tag, input logic [31:0] rd, input logic exc, input logic v);
    chk({tag, ".rdata"}, bus.W_DM_rdata, rd);
    chk({tag, ".exc"},   {31'h0, bus.W_DM_exc}, {31'h0, exc});
    chk({tag, ".valid"}, {31'h0, bus.W_valid},  {31'h0, v});
  endtask

  // Drive one M cycle, then step past the edge that captures it.
  task automatic op(input logic v, input logic we, input logic re,
                    input logic [2:0] opc, input logic [31:0] a, input logic [31:0] wd);
    bus.M_valid = v;
    bus.M_DM_WE = we;
    bus.M_DM_re = re;
    bus.M_DM_op = opc;
    bus.M_addr  = a;
    bus.M_wdata = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic st(input logic [2:0] opc, input logic [31:0] a, input logic [31:0] wd);
    op(1'b1, 1'b1, 1'b0, opc, a, wd);
  endtask

  task automatic ld(input logic [2:0] opc, input logic [31:0] a);
    op(1'b1, 1'b0, 1'b1, opc, a, 32'h0);
  endtask

  initial begin
    bus.M_valid = 1'b0; bus.M_DM_WE = 1'b0; bus.M_DM_re = 1'b0;
    bus.M_DM_op = W;    bus.M_addr  = '0;   bus.M_wdata = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    expw("in_reset", 32'h0, 1'b0, 1'b0);
    reset = 1'b1;

    ld(W, 32'h0);                 expw("lw0_after_reset", 32'h0, 1'b0, 1'b1);

    // store then load word
    st(W, 32'h10, 32'h12345678);  expw("sw10", 32'h0, 1'b0, 1'b1);
    ld(W, 32'h10);                expw("lw10", 32'h12345678, 1'b0, 1'b1);

    // byte / half lanes (upper data bits must be ignored)
    st(B, 32'h11, 32'hFFFFFFAB);
    ld(W, 32'h10);                expw("sb11", 32'h1234AB78, 1'b0, 1'b1);
    st(H, 32'h12, 32'h1111BEEF);
    ld(W, 32'h10);                expw("sh12", 32'hBEEFAB78, 1'b0, 1'b1);

    // extension over 0x8001FF80
    st(W, 32'h20, 32'h8001FF80);
    ld(B,  32'h20);               expw("lb20",  32'hFFFFFF80, 1'b0, 1'b1);
    ld(BU, 32'h20);               expw("lbu20", 32'h00000080, 1'b0, 1'b1);
    ld(H,  32'h22);               expw("lh22",  32'hFFFF8001, 1'b0, 1'b1);
    ld(HU, 32'h22);               expw("lhu22", 32'h00008001, 1'b0, 1'b1);
    ld(BU, 32'h21);               expw("lbu21", 32'h000000FF, 1'b0, 1'b1);
    ld(B,  32'h22);               expw("lb22",  32'h00000001, 1'b0, 1'b1);
    ld(H,  32'h20);               expw("lh20",  32'hFFFFFF80, 1'b0, 1'b1);

    // alignment faults
    st(W, 32'h21, 32'hDEADBEEF);  expw("sw21_fault", 32'h0, 1'b1, 1'b1);
    ld(W, 32'h20);                expw("lw20_unchanged", 32'h8001FF80, 1'b0, 1'b1);
    st(HU, 32'h21, 32'h0000CAFE); expw("sh21_fault", 32'h0, 1'b1, 1'b1);
    ld(H, 32'h23);                expw("lh23_fault", 32'h0, 1'b1, 1'b1);
    ld(W, 32'h20);                expw("lw20_unchanged2", 32'h8001FF80, 1'b0, 1'b1);

    // top-of-array boundary and range faults
    st(B, 32'hFFF, 32'h0000005A);
    ld(BU, 32'hFFF);              expw("lbu_fff", 32'h0000005A, 1'b0, 1'b1);
    ld(HU, 32'hFFE);              expw("lhu_ffe", 32'h00005A00, 1'b0, 1'b1);
    ld(W,  32'hFFC);              expw("lw_ffc",  32'h5A000000, 1'b0, 1'b1);
    ld(W, 32'h1000);              expw("lw1000_fault", 32'h0, 1'b1, 1'b1);
    ld(W, 32'hFFFFFFFC);          expw("lw_high_fault", 32'h0, 1'b1, 1'b1);
    st(W, 32'h1010, 32'h55555555); expw("sw1010_fault", 32'h0, 1'b1, 1'b1);
    ld(W, 32'h10);                expw("lw10_no_alias", 32'hBEEFAB78, 1'b0, 1'b1);

    // reserved op codes
    ld(3'b111, 32'h10);           expw("op111_load", 32'h0, 1'b1, 1'b1);
    op(1'b1, 1'b1, 1'b0, 3'b101, 32'h10, 32'h0);
                                  expw("op101_store", 32'h0, 1'b1, 1'b1);
    ld(W, 32'h10);                expw("lw10_after_rsvd", 32'hBEEFAB78, 1'b0, 1'b1);

    // bubble and non-access cycles
    op(1'b0, 1'b1, 1'b0, W, 32'h10, 32'hFFFFFFFF);
                                  expw("bubble_sw", 32'h0, 1'b0, 1'b0);
    op(1'b0, 1'b0, 1'b1, W, 32'h10, 32'h0);
                                  expw("bubble_lw", 32'h0, 1'b0, 1'b0);
    op(1'b1, 1'b0, 1'b0, W, 32'h21, 32'h0);
                                  expw("nonmem_misaligned", 32'h0, 1'b0, 1'b1);
    ld(W, 32'h10);                expw("lw10_after_bubble", 32'hBEEFAB78, 1'b0, 1'b1);

    // reset mid-run: outputs clear immediately, in-flight store lost
    #2 reset = 1'b0;
    #1;
    expw("async_reset", 32'h0, 1'b0, 1'b0);
    st(W, 32'h30, 32'h77777777);  expw("store_in_reset", 32'h0, 1'b0, 1'b0);
    reset = 1'b1;
    ld(W, 32'h30);                expw("lw30_after_reset", 32'h0, 1'b0, 1'b1);
    ld(W, 32'h10);                expw("lw10_after_reset", 32'h0, 1'b0, 1'b1);
    ld(W, 32'h20);                expw("lw20_after_reset", 32'h0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dm_resp.md
# dm_resp

Memory-stage data-memory responder for the five-stage MIPS pipeline. It accepts one load or store per cycle from the M-stage controller (write enable, access width/sign code, byte address, store data) and keeps the data memory array. It performs byte-lane writes and load extraction and sign/zero extension. It registers the load result and an alignment/range fault flag into the M/W boundary for the W stage.

## Interface
- `WORDS`, 1024: number of 32-bit words in the array. The byte address space is 0 to 4*WORDS-1.
- `clk  input  1`: pipeline clock; all state updates on the rising edge.
- `reset  input  1`: asynchronous, active-low; clears all state.
- `M_valid  input  1`: M-stage instruction is real. When 0 (bubble), nothing is written and `W_valid` is loaded with 0.
- `M_DM_WE  input  1`: 1 = store, 0 = load or non-memory instruction.
- `M_DM_re  input  1`: 1 = load. `M_DM_WE` and `M_DM_re` are never both 1.
- `M_DM_op  input  3`: access code.
  - 000 = word.
  - 001 = half, unsigned.
  - 010 = half, signed.
  - 011 = byte, unsigned.
  - 100 = byte, signed.
  - 101–111 are reserved; treat as a fault.
- `M_addr  input  32`: byte address from the ALU.
- `M_wdata  input  32`: store data (already forwarded). sh uses bits [15:0]; sb uses bits [7:0].
- `W_valid  output  1`: registered copy of `M_valid`.
- `W_DM_rdata  output  32`: registered, extended load result. It is 0 for non-loads and for faulted accesses.
- `W_DM_exc  output  1`: registered fault flag for the access in W.

## Operation
- Storage: `WORDS` x 32-bit array. The word index is `M_addr[31:2]`.
- Access condition: the cycle has an access when `M_valid` & (`M_DM_WE` | `M_DM_re`). A fault is raised when any of the following holds:
  - `M_addr` ≥ 4*WORDS;
  - word access with `M_addr[1:0]` ≠ 0;
  - half access with `M_addr[0]` ≠ 0;
  - reserved `M_DM_op`.
- Store (no fault): write the byte lanes selected by `M_addr[1:0]`; all other lanes are unchanged.
  - Word: all 4 lanes.
  - Half: lanes {1,0} if `M_addr[1]`=0, else lanes {3,2}. Data is `M_wdata[15:0]`.
  - Byte: lane `M_addr[1:0]`. Data is `M_wdata[7:0]`.
  - Signed and unsigned codes behave the same for stores.
- Store with a fault: the array is unchanged and `W_DM_exc`=1 next cycle.
- Load (no fault): read the addressed word combinationally and select the lane.
  - Half: `M_addr[1]` picks the upper or lower halfword.
  - Byte: `M_addr[1:0]` picks the byte.
  - Zero- or sign-extend to 32 bits per `M_DM_op`, then register into `W_DM_rdata`.
- Load with a fault: `W_DM_rdata`=0 and `W_DM_exc`=1.
- Non-access or bubble cycle: `W_DM_rdata`=0 and `W_DM_exc`=0.

## Timing
- Reset (`reset`=0, asynchronous): every array word becomes 0x00000000. `W_valid`=0, `W_DM_rdata`=0, `W_DM_exc`=0. All are held until `reset` deasserts.
- Store latency: the array is updated at the rising edge that ends the M cycle. A load issued in the next cycle to the same word returns the new data. No bypass is needed because there is one access per cycle.
- Load latency: 1 cycle. Data is presented in M and appears on `W_DM_rdata` after the next rising edge, aligned with `W_valid`.
- The M/W register loads every cycle. There is no stall input; the pipeline never stalls M.
- Reset asserted mid-operation: any in-flight store at that edge is lost, and the array and outputs clear immediately.
- Address wrap-around: none. Addresses ≥ 4*WORDS are faults, never aliased.
- The highest legal word is 4*WORDS-4. A byte load at 4*WORDS-1 is legal; a half at 4*WORDS-2 is legal.

## Test plan
- Reset: after reset, lw 0x0 → `W_DM_rdata`=0x00000000, `W_DM_exc`=0, `W_valid`=1.
- Store then load word: sw 0x12345678 at 0x10, then lw 0x10 in the next cycle → 0x12345678 one cycle later.
- Byte/half lanes:
  - Over word 0x12345678: sb 0xAB at 0x11 → lw 0x10 = 0x1234AB78.
  - sh 0xBEEF at 0x12 → lw 0x10 = 0xBEEFAB78.
- Extension: with 0x8001FF80 at 0x20:
  - lb 0x20 → 0xFFFFFF80; lbu 0x20 → 0x00000080.
  - lh 0x22 → 0xFFFF8001; lhu 0x22 → 0x00008001.
- Faults:
  - sw at 0x21 → array unchanged, `W_DM_exc`=1.
  - lw at 0x1000 (WORDS=1024) → `W_DM_rdata`=0, `W_DM_exc`=1.
  - `M_DM_op`=111 load → fault.
- Bubble and reset mid-run:
  - `M_valid`=0 with `M_DM_WE`=1 → no write, `W_valid`=0.
  - Assert `reset` between two edges after stores → all outputs are 0 immediately, and a later load returns 0.
